// File: rtl/scan_chain_reader_pkg.sv
// Shared definitions for the scan chain reader:
// FSM state encodings, word geometry and counter width.
package scan_chain_reader_pkg;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 16;
    localparam int WIDX_W = 5;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ACK    = 3'd1;
    localparam logic [2:0] ST_SHIFT  = 3'd2;
    localparam logic [2:0] ST_FLUSH  = 3'd3;
    localparam logic [2:0] ST_COMMIT = 3'd4;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [WIDX_W-1:0] widx_t;
    typedef logic [CNT_W-1:0]  bcnt_t;

endpackage

// File: rtl/scan_chain_reader_if.sv
// Control handshake, result bus and serial chain
// signals between the control unit and the reader.
interface scan_chain_reader_if;
    import scan_chain_reader_pkg::*;

    logic       val_op;
    logic       op_ack;
    logic       op_commit;
    logic       commit_ack;
    logic       output_strobe;
    word_t      output_data;
    logic       scan_en;
    logic       scan_in;
    logic       scan_out;
    logic [2:0] state;

    modport master (
        output val_op,
        output commit_ack,
        output scan_out,
        input  op_ack,
        input  op_commit,
        input  output_strobe,
        input  output_data,
        input  scan_en,
        input  scan_in,
        input  state
    );

    modport slave (
        input  val_op,
        input  commit_ack,
        input  scan_out,
        output op_ack,
        output op_commit,
        output output_strobe,
        output output_data,
        output scan_en,
        output scan_in,
        output state
    );

endinterface

// File: rtl/scan_chain_reader_counter.sv
// Wrapping up-counter 0..MAX with synchronous
// clear; used as the chain bit counter.
module simple_counter #(
    parameter int              WIDTH = 16,
    parameter logic [WIDTH-1:0] MAX  = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             cnten,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (cnten) begin
            if (count == MAX) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/scan_chain_reader.sv
// Unloads an attached scan chain into 32-bit words,
// optionally recirculating the bits so the chain survives.
module scan_chain_reader
    import scan_chain_reader_pkg::*;
#(
    parameter int SC_LEN = 64,
    parameter bit RECIRC = 1'b1
) (
    input logic          clk,
    input logic          reset,
    scan_chain_reader_if.slave bus
);

    localparam bcnt_t LAST = bcnt_t'(SC_LEN - 1);

    logic [2:0] st;
    logic [2:0] st_nxt;
    bcnt_t      bit_cnt;
    widx_t      widx;
    word_t      acc;
    word_t      word_nxt;
    word_t      data_q;
    logic       strobe_q;
    logic       in_shift;
    logic       shift_entry;
    logic       last_bit;
    logic       word_done;

    assign in_shift    = (st == ST_SHIFT);
    assign shift_entry = (st == ST_ACK) && !bus.val_op;
    assign last_bit    = in_shift && (bit_cnt == LAST);
    assign word_done   = (widx == widx_t'(WORD_W - 1)) || last_bit;

    simple_counter #(
        .WIDTH (CNT_W),
        .MAX   (LAST)
    ) u_bit_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (shift_entry),
        .cnten (in_shift),
        .count (bit_cnt)
    );

    always_comb begin
        st_nxt = st;
        case (st)
            ST_IDLE: begin
                if (bus.val_op) st_nxt = ST_ACK;
            end
            ST_ACK: begin
                if (!bus.val_op) st_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (last_bit) st_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                st_nxt = ST_COMMIT;
            end
            ST_COMMIT: begin
                if (bus.commit_ack) st_nxt = ST_IDLE;
            end
            default: begin
                st_nxt = ST_IDLE;
            end
        endcase
    end

    // A new word starts from zero so unfilled upper bits read as 0.
    always_comb begin
        word_nxt = (widx == '0) ? '0 : acc;
        word_nxt[widx] = bus.scan_out;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st       <= ST_IDLE;
            widx     <= '0;
            acc      <= '0;
            strobe_q <= 1'b0;
            data_q   <= '0;
        end else begin
            st       <= st_nxt;
            strobe_q <= 1'b0;
            if (shift_entry) begin
                widx <= '0;
            end else if (in_shift) begin
                widx <= widx + 1'b1;
                acc  <= word_nxt;
                if (word_done) begin
                    strobe_q <= 1'b1;
                    data_q   <= word_nxt;
                end
            end
        end
    end

    assign bus.state         = st;
    assign bus.op_ack        = (st == ST_ACK);
    assign bus.op_commit     = (st == ST_COMMIT);
    assign bus.scan_en       = in_shift;
    assign bus.scan_in       = (RECIRC && in_shift) ? bus.scan_out : 1'b0;
    assign bus.output_strobe = strobe_q;
    assign bus.output_data   = data_q;

endmodule

// File: tb/tb_scan_chain_reader.sv
// Randomised bench for scan_chain_reader: three chain
// lengths (64, 40, 1) checked against a cycle-offset model.
module tb_scan_chain_reader;

    typedef struct packed {
        logic [2:0]  st;
        logic        ack;
        logic        com;
        logic        stb;
        logic        en;
        logic        sin;
        logic [31:0] data;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    int   tcyc  = 0;
    logic started = 1'b0;
    int   sidx[3];
    int   last_ack[3];
    logic pcom[3];

    for (genvar gi = 0; gi < 3; gi++) begin : g
        localparam int L = (gi == 0) ? 64 : (gi == 1) ? 40 : 1;
        localparam logic [63:0] PRE =
            (gi == 0) ? 64'hA5A5A5A5_0F0F0F0F :
            (gi == 1) ? 64'h000000FF_FFFFFFFF : 64'h1;

        scan_chain_reader_if bus();
        logic rst;
        logic tmo;
        logic done;
        logic [L-1:0] chain;
        logic [L-1:0] snap = '0;
        logic [31:0] last_word = '0;
        logic chain_ok;
        int cyc = 0;
        int f = 0;
        int mode = 0;
        obs_t obs;
        obs_t ex;

        scan_chain_reader #(
            .SC_LEN (L),
            .RECIRC (1'b1)
        ) dut (
            .clk   (clk),
            .reset (rst),
            .bus   (bus)
        );

        // Chain stand-in: bit 0 is shifted out first.
        always @(posedge clk) begin
            if (rst) begin
                chain <= PRE[L-1:0];
            end else if (bus.scan_en) begin
                for (int i = 0; i < L - 1; i++) chain[i] <= chain[i+1];
                chain[L-1] <= bus.scan_in;
            end
        end
        assign bus.scan_out = chain[0];
        assign chain_ok = (chain == PRE[L-1:0]);

        assign obs = {bus.state, bus.op_ack, bus.op_commit,
                      bus.output_strobe, bus.scan_en, bus.scan_in,
                      bus.output_data};

        // mode: 0 idle, 1 acknowledged, 2 unload running since cycle f.
        always @(posedge clk) begin
            cyc <= cyc + 1;
            if (rst) begin
                mode      <= 0;
                last_word <= '0;
            end else begin
                if (ex.stb) last_word <= ex.data;
                case (mode)
                    0: if (bus.val_op) mode <= 1;
                    1: if (!bus.val_op) begin
                        mode <= 2;
                        f    <= cyc;
                        snap <= chain;
                    end
                    2: if (cyc - f >= L + 2 && bus.commit_ack) mode <= 0;
                    default: mode <= 0;
                endcase
            end
        end

        always_comb begin
            int k;
            int base;
            logic [31:0] w;
            k = cyc - f;
            base = 0;
            w = '0;
            ex = '0;
            ex.data = last_word;
            if (mode == 1) begin
                ex.st  = 3'd1;
                ex.ack = 1'b1;
            end else if (mode == 2) begin
                if (k <= L) begin
                    ex.st  = 3'd2;
                    ex.en  = 1'b1;
                    ex.sin = snap[k-1];
                end else if (k == L + 1) begin
                    ex.st = 3'd3;
                end else begin
                    ex.st  = 3'd4;
                    ex.com = 1'b1;
                end
                if (k >= 2 && k <= L + 1 &&
                    (((k - 2) % 32) == 31 || (k - 2) == L - 1)) begin
                    ex.stb = 1'b1;
                    base = 32 * ((k - 2) / 32);
                    for (int b = 0; b < 32; b++)
                        if (base + b < L) w[b] = snap[base+b];
                    ex.data = w;
                end
            end
        end

        task automatic step();
            @(posedge clk);
            #2;
        endtask

        initial begin
            rst = 1'b1;
            tmo = 1'b0;
            done = 1'b0;
            bus.val_op = 1'b0;
            bus.commit_ack = 1'b0;
            repeat (3) @(posedge clk);
            #2 rst = 1'b0;
            for (int t = 0; t < 7; t++) begin
                repeat ($urandom_range(0, 3)) step();
                bus.val_op = 1'b1;
                for (int w = 0; w < 10 && !bus.op_ack; w++) step();
                if (!bus.op_ack) tmo = 1'b1;
                repeat ((t == 0) ? 2 : $urandom_range(0, 3)) step();
                bus.val_op = 1'b0;
                if (t == 2 && L > 20) begin
                    for (int w = 0; w < 5 && !bus.scan_en; w++) step();
                    repeat (19) step();
                    rst = 1'b1;
                    step();
                    rst = 1'b0;
                    continue;
                end
                if (L >= 8 && $urandom_range(0, 1) == 1) begin
                    for (int w = 0; w < 5 && !bus.scan_en; w++) step();
                    repeat (2) step();
                    bus.val_op = 1'b1;
                    repeat (2) step();
                    bus.val_op = 1'b0;
                end
                for (int w = 0; w < L + 20 && !bus.op_commit; w++) step();
                if (!bus.op_commit) tmo = 1'b1;
                repeat ((t == 1) ? 10 : $urandom_range(0, 12)) step();
                bus.commit_ack = 1'b1;
                if ($urandom_range(0, 3) == 0) bus.val_op = 1'b1;
                step();
                bus.commit_ack = 1'b0;
            end
            bus.val_op = 1'b0;
            repeat (6) step();
            done = 1'b1;
        end
    end

    function automatic logic [31:0] lit_word(input int id, input int j);
        case (id)
            0: return (j == 0) ? 32'h0F0F0F0F :
                      (j == 1) ? 32'hA5A5A5A5 : 32'hDEADBEEF;
            1: return (j == 0) ? 32'hFFFFFFFF :
                      (j == 1) ? 32'h000000FF : 32'hDEADBEEF;
            default: return (j == 0) ? 32'h00000001 : 32'hDEADBEEF;
        endcase
    endfunction

    function automatic int lit_lat(input int id);
        case (id)
            0: return 66;
            1: return 42;
            default: return 3;
        endcase
    endfunction

    function automatic int lit_ns(input int id);
        return (id == 2) ? 1 : 2;
    endfunction

    task automatic chk(input int id, input string nm,
                       input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL dut%0d %s: got %h want %h (cycle %0d)",
                     id, nm, act, exp, tcyc);
        end
    endtask

    task automatic cmp_dut(input int id, input obs_t o, input obs_t e,
                           input logic cok, input logic to);
        chk(id, "timeout", 32'(to), 32'd0);
        chk(id, "state", 32'(o.st), 32'(e.st));
        chk(id, "op_ack", 32'(o.ack), 32'(e.ack));
        chk(id, "op_commit", 32'(o.com), 32'(e.com));
        chk(id, "strobe", 32'(o.stb), 32'(e.stb));
        chk(id, "scan_en", 32'(o.en), 32'(e.en));
        chk(id, "scan_in", 32'(o.sin), 32'(e.sin));
        chk(id, "data", o.data, e.data);
        if (o.ack) begin
            sidx[id] = 0;
            last_ack[id] = tcyc;
        end
        if (o.stb) begin
            chk(id, "lit_word", o.data, lit_word(id, sidx[id]));
            sidx[id]++;
        end
        if (o.com && !pcom[id]) begin
            chk(id, "lit_latency", 32'(tcyc - last_ack[id]), 32'(lit_lat(id)));
            chk(id, "lit_strobes", 32'(sidx[id]), 32'(lit_ns(id)));
            chk(id, "chain_kept", 32'(cok), 32'd1);
        end
        pcom[id] = o.com;
    endtask

    always @(negedge clk) begin
        if (started) begin
            tcyc++;
            cmp_dut(0, g[0].obs, g[0].ex, g[0].chain_ok, g[0].tmo);
            cmp_dut(1, g[1].obs, g[1].ex, g[1].chain_ok, g[1].tmo);
            cmp_dut(2, g[2].obs, g[2].ex, g[2].chain_ok, g[2].tmo);
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            sidx[i] = 0;
            last_ack[i] = 0;
            pcom[i] = 1'b0;
        end
        repeat (4) @(posedge clk);
        started = 1'b1;
        for (int c = 0; c < 20000 &&
             !(g[0].done && g[1].done && g[2].done); c++)
            @(posedge clk);
        if (!(g[0].done && g[1].done && g[2].done)) begin
            $display("FAIL global_timeout: drivers did not finish");
            $fatal(1, "bench stalled");
        end
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
